move_collector: RTL and testbench
=================================

# move_collector

Input stage in front of the Morra cinese game core. It collects one move per player through independent valid/ready handshakes and presents each completed pair to the core as a single-cycle `primo`/`secondo` pulse, driving `00/00` otherwise. It also sequences the core's game-start reset, carrying the extra-rounds setup value. It stops accepting moves once the core reports a game result on `partita`.

## Interface
- `TIMEOUT`, 255: cycles a lone pending move waits for the other player; legal range 1..1023.
- `COOLDOWN`, 1: idle cycles forced after each issued pair; legal range 0..15.

- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `start`  in  1  single-cycle request to begin a new game
- `setup`  in  4  extra-rounds value; sampled in the cycle `start` is high
- `p1_valid`  in  1  player-1 move offered
- `p1_move`  in  2  player-1 move: 01 sasso, 10 carta, 11 forbice, 00 none
- `p1_ready`  out  1  player-1 slot empty and accepting
- `p2_valid`, `p2_move`, `p2_ready`: same as player 1, for player 2
- `partita`  in  2  core game result; 00 means the game is still running
- `core_reset`  out  1  reset to the core
- `primo`  out  2  player-1 move to the core
- `secondo`  out  2  player-2 move to the core
- `timeout`  out  1  one-cycle pulse when a pending move is dropped

## Operation
- All outputs are registered.
- **Reset values:**
  - state IDLE
  - `core_reset`=1
  - `primo`=`secondo`=00
  - `p1_ready`=`p2_ready`=0
  - `timeout`=0
  - both slots empty; counters 0
- **IDLE:** `core_reset`=0, ready=0. `start` moves the block to START.
- **START (1 cycle):**
  - `core_reset`=1, `primo`=`setup[3:2]`, `secondo`=`setup[1:0]`.
  - Moves to COLLECT.
- **COLLECT:**
  - `pN_ready`=1 while slot N is empty.
  - A move is accepted when `pN_valid && pN_ready && pN_move!=00`.
  - A `valid` with move 00 is ignored.
  - A full slot holds its first move; later offers are not accepted.
  - When both slots are full, the block moves to ISSUE.
- **ISSUE (1 cycle):**
  - `primo`/`secondo` carry the latched moves; both slots clear.
  - Moves to COOL if `COOLDOWN>0`, otherwise to COLLECT.
- **COOL:** ready=0 and outputs 00 for `COOLDOWN` cycles, then the block moves to COLLECT.
- **DONE:**
  - `partita!=00` sampled in COLLECT or COOL moves the block to DONE and clears both slots.
  - In DONE, ready=0 and outputs 00 until `start`.
- **start handling:**
  - `start` in any state other than reset moves the block to START next cycle and clears slots and counters.
  - A move offered in the same cycle as `start` is discarded.
- **reset:** `reset` overrides everything, including mid-START or mid-ISSUE.
- **Output default:** in every state except START and ISSUE, `primo`=`secondo`=00.

## Timing
- Acceptance edge N: `pN_ready` is 0 from cycle N+1.
- Latency from the edge that fills the second slot to the ISSUE cycle is 1 cycle. This also holds when both players are accepted on the same edge.
- ISSUE is exactly 1 cycle wide; it is never repeated for the same pair.
- Minimum spacing between two ISSUE cycles is `COOLDOWN`+2 cycles (ISSUE, COOL×`COOLDOWN`, ≥1 COLLECT cycle).
- `start` to `core_reset`=1 is 1 cycle; `core_reset` is high for exactly 1 cycle.
- `partita` is sampled each cycle. The core's result arrives after the ISSUE that ends the game, so a move accepted before that result is discarded on entry to DONE.

## Configuration
- `MOVE_TIMEOUT_EN` defined:
  - A 10-bit counter runs while exactly one slot is full.
  - The counter clears when slots become both-empty or both-full.
  - When the counter reaches `TIMEOUT`, the full slot is cleared, `timeout` pulses for 1 cycle and the counter returns to 0.
  - If the missing move is accepted on the same edge the count reaches `TIMEOUT`, the acceptance wins: ISSUE follows and there is no timeout pulse.
- `MOVE_TIMEOUT_EN` undefined: a lone move waits indefinitely; `timeout` is tied to 0; no counter logic is built.

## Test plan
- Reset, then `start` with `setup`=4'b0110 -> next cycle `core_reset`=1, `primo`=01, `secondo`=10 for 1 cycle; then `p1_ready`=`p2_ready`=1.
- P1 offers 01, P2 offers 11 three cycles later -> ISSUE 1 cycle after P2 acceptance with `primo`=01, `secondo`=11; COOL for 1 cycle (`COOLDOWN`=1) with ready=0 and outputs 00.
- Both offer (10, 10) in the same cycle; P1 offers 11 again while its slot is full; P1 offers move 00 -> single ISSUE with 10/10; the second offer is not accepted; the 00 offer is ignored.
- Drive `partita`=01 during COOL with P1 holding 11 offered -> DONE, ready=0, outputs 00; a later `start` restarts via START.
- `MOVE_TIMEOUT_EN`, `TIMEOUT`=5, P1 offers 11 and P2 stays idle -> 5 cycles after acceptance the slot clears, `timeout`=1 for 1 cycle, `p1_ready`=1; no ISSUE.
- `start` asserted in the same cycle P2's move completes the pair -> no ISSUE; START follows; slots empty.

Source files
------------

// File: rtl/move_collector.sv
// move_collector: collects one move per player and issues each pair to the Morra core.
// Optional MOVE_TIMEOUT_EN drops a lone pending move after TIMEOUT cycles.
module move_collector #(
    parameter int TIMEOUT  = 255,
    parameter int COOLDOWN = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] setup,
    input  logic       p1_valid,
    input  logic [1:0] p1_move,
    output logic       p1_ready,
    input  logic       p2_valid,
    input  logic [1:0] p2_move,
    output logic       p2_ready,
    input  logic [1:0] partita,
    output logic       core_reset,
    output logic [1:0] primo,
    output logic [1:0] secondo,
    output logic       timeout
);
    typedef enum logic [2:0] {IDLE, START, COLLECT, ISSUE, COOL, DONE} state_t;
    state_t state, state_n;
    logic v1, v2, v1_n, v2_n;
    logic [1:0] m1, m2, m1_n, m2_n;
    logic [3:0] cnt, cnt_n;
    logic acc1, acc2, quit, expire, clr;

    always_comb begin
        acc1 = p1_ready && p1_valid && p1_move != 2'b00 && !start;
        acc2 = p2_ready && p2_valid && p2_move != 2'b00 && !start;
        quit = partita != 2'b00 && (state == COLLECT || state == COOL);
        m1_n = acc1 ? p1_move : m1;
        m2_n = acc2 ? p2_move : m2;
        state_n = state;
        if (start)
            state_n = START;
        else if (quit)
            state_n = DONE;
        else
            case (state)
                START:   state_n = COLLECT;
                COLLECT: state_n = ((v1 || acc1) && (v2 || acc2)) ? ISSUE : COLLECT;
                ISSUE:   state_n = COOLDOWN > 0 ? COOL : COLLECT;
                COOL:    state_n = cnt == 4'(COOLDOWN - 1) ? COLLECT : COOL;
                default: state_n = state;
            endcase
        // slots empty on restart, game end, timeout and when the pair is handed over
        clr = start || quit || expire || state_n == ISSUE;
        v1_n = (v1 || acc1) && !clr;
        v2_n = (v2 || acc2) && !clr;
        cnt_n = (state == COOL && state_n == COOL) ? cnt + 4'd1 : 4'd0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            v1         <= 1'b0;
            v2         <= 1'b0;
            m1         <= 2'b00;
            m2         <= 2'b00;
            cnt        <= 4'd0;
            core_reset <= 1'b1;
            primo      <= 2'b00;
            secondo    <= 2'b00;
            p1_ready   <= 1'b0;
            p2_ready   <= 1'b0;
        end else begin
            state      <= state_n;
            v1         <= v1_n;
            v2         <= v2_n;
            m1         <= m1_n;
            m2         <= m2_n;
            cnt        <= cnt_n;
            core_reset <= state_n == START;
            primo      <= state_n == START ? setup[3:2] : state_n == ISSUE ? m1_n : 2'b00;
            secondo    <= state_n == START ? setup[1:0] : state_n == ISSUE ? m2_n : 2'b00;
            p1_ready   <= state_n == COLLECT && !v1_n;
            p2_ready   <= state_n == COLLECT && !v2_n;
        end
    end

`ifdef MOVE_TIMEOUT_EN
    logic [9:0] tcnt;
    // a late acceptance of the missing move beats the expiry on the same edge
    assign expire = state == COLLECT && !start && !quit && (v1 ^ v2) && !(acc1 || acc2)
                    && tcnt == 10'(TIMEOUT - 1);
    always_ff @(posedge clk) begin
        if (reset) begin
            tcnt    <= 10'd0;
            timeout <= 1'b0;
        end else begin
            tcnt    <= (state_n == COLLECT && (v1 ^ v2) && (v1_n ^ v2_n)) ? tcnt + 10'd1 : 10'd0;
            timeout <= expire;
        end
    end
`else
    assign expire  = 1'b0;
    assign timeout = 1'b0;
`endif
endmodule

// File: tb/tb_move_collector.sv
// tb_move_collector: directed table, hand sequences and randomized run against a behavioural model.
module tb_move_collector;
    localparam int TO = 5;
    localparam int CD = 1;
    localparam int M_IDLE = 0, M_START = 1, M_COLLECT = 2, M_ISSUE = 3, M_COOL = 4, M_DONE = 5;

    logic clk = 1'b0;
    logic reset, start, p1_valid, p2_valid;
    logic [3:0] setup;
    logic [1:0] p1_move, p2_move, partita;
    logic p1_ready, p2_ready, core_reset, timeout;
    logic [1:0] primo, secondo;
    logic [7:0] got;

    int n_cmp = 0;
    int n_bad = 0;

    move_collector #(.TIMEOUT(TO), .COOLDOWN(CD)) dut (
        .clk(clk), .reset(reset), .start(start), .setup(setup),
        .p1_valid(p1_valid), .p1_move(p1_move), .p1_ready(p1_ready),
        .p2_valid(p2_valid), .p2_move(p2_move), .p2_ready(p2_ready),
        .partita(partita), .core_reset(core_reset), .primo(primo),
        .secondo(secondo), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // {core_reset, primo, secondo, p1_ready, p2_ready, timeout}
    assign got = {core_reset, primo, secondo, p1_ready, p2_ready, timeout};

    typedef struct {
        logic       st;
        logic [3:0] su;
        logic       v1;
        logic [1:0] m1;
        logic       v2;
        logic [1:0] m2;
        logic [1:0] pa;
        logic [7:0] exp;
    } vec_t;

    // behavioural model state
    int ph;
    bit full[2];
    logic [1:0] mv[2];
    int cool_left, wcnt;
    logic [7:0] mexp;

    task automatic model_step(input logic rs, input logic st, input logic [3:0] su,
                              input logic v1, input logic [1:0] m1,
                              input logic v2, input logic [1:0] m2, input logic [1:0] pa);
        logic vv[2];
        logic [1:0] mm[2];
        bit acc[2];
        bit was_one, tmo;
        logic [1:0] pr, se;
        vv = '{v1, v2};
        mm = '{m1, m2};
        tmo = 1'b0;
        if (rs) begin
            ph = M_IDLE; full = '{0, 0}; wcnt = 0; cool_left = 0;
            mexp = 8'b1_00_00_0_0_0;
            return;
        end
        for (int i = 0; i < 2; i++) acc[i] = mexp[2-i] && vv[i] && mm[i] != 2'b00 && !st;
        if (st) begin
            ph = M_START; full = '{0, 0}; wcnt = 0; cool_left = 0;
        end else if ((ph == M_COLLECT || ph == M_COOL) && pa != 2'b00) begin
            ph = M_DONE; full = '{0, 0}; wcnt = 0;
        end else begin
            case (ph)
                M_START: ph = M_COLLECT;
                M_COLLECT: begin
                    was_one = full[0] != full[1];
                    for (int i = 0; i < 2; i++)
                        if (acc[i]) begin full[i] = 1'b1; mv[i] = mm[i]; end
                    if (full[0] && full[1]) begin
                        ph = M_ISSUE; full = '{0, 0}; wcnt = 0;
                    end else if (was_one) begin
                        wcnt++;
`ifdef MOVE_TIMEOUT_EN
                        if (wcnt == TO) begin full = '{0, 0}; tmo = 1'b1; wcnt = 0; end
`endif
                    end else wcnt = 0;
                end
                M_ISSUE: if (CD > 0) begin ph = M_COOL; cool_left = CD; end else ph = M_COLLECT;
                M_COOL: begin
                    cool_left--;
                    if (cool_left == 0) ph = M_COLLECT;
                end
                default: ;
            endcase
        end
        pr = ph == M_START ? su[3:2] : ph == M_ISSUE ? mv[0] : 2'b00;
        se = ph == M_START ? su[1:0] : ph == M_ISSUE ? mv[1] : 2'b00;
        mexp = {ph == M_START, pr, se, ph == M_COLLECT && !full[0], ph == M_COLLECT && !full[1], tmo};
    endtask

    task automatic cyc(input logic st, input logic [3:0] su, input logic v1, input logic [1:0] m1,
                       input logic v2, input logic [1:0] m2, input logic [1:0] pa);
        start = st; setup = su; p1_valid = v1; p1_move = m1;
        p2_valid = v2; p2_move = m2; partita = pa;
        @(posedge clk);
        model_step(reset, st, su, v1, m1, v2, m2, pa);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 4'h0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00);
    endtask

    task automatic check(input string name, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    function automatic vec_t row(input logic st, input logic [3:0] su, input logic v1, input logic [1:0] m1,
                                 input logic v2, input logic [1:0] m2, input logic [1:0] pa,
                                 input logic [7:0] exp);
        row = '{st, su, v1, m1, v2, m2, pa, exp};
    endfunction

    vec_t tbl[25];

    initial begin
        tbl[0]  = row(0, 4'h0, 0, 2'b00, 0, 2'b00, 2'b00, 8'b0_00_00_0_0_0);
        tbl[1]  = row(1, 4'b0110, 0, 2'b00, 0, 2'b00, 2'b00, 8'b1_01_10_0_0_0);
        tbl[2]  = row(0, 4'h0, 0, 2'b00, 0, 2'b00, 2'b00, 8'b0_00_00_1_1_0);
        tbl[3]  = row(0, 4'h0, 1, 2'b01, 0, 2'b00, 2'b00, 8'b0_00_00_0_1_0);
        tbl[4]  = row(0, 4'h0, 0, 2'b00, 0, 2'b00, 2'b00, 8'b0_00_00_0_1_0);
        tbl[5]  = row(0, 4'h0, 0, 2'b00, 0, 2'b00, 2'b00, 8'b0_00_00_0_1_0);
        tbl[6]  = row(0, 4'h0, 0, 2'b00, 1, 2'b11, 2'b00, 8'b0_01_11_0_0_0);
        tbl[7]  = row(0, 4'h0, 0, 2'b00, 0, 2'b00, 2'b00, 8'b0_00_00_0_0_0);
        tbl[8]  = row(0, 4'h0, 0, 2'b00, 0, 2'b00, 2'b00, 8'b0_00_00_1_1_0);
        tbl[9]  = row(0, 4'h0, 1, 2'b00, 0, 2'b00, 2'b00, 8'b0_00_00_1_1_0);
        tbl[10] = row(0, 4'h0, 1, 2'b10, 1, 2'b10, 2'b00, 8'b0_10_10_0_0_0);
        tbl[11] = row(0, 4'h0, 1, 2'b11, 0, 2'b00, 2'b00, 8'b0_00_00_0_0_0);
        tbl[12] = row(0, 4'h0, 0, 2'b00, 0, 2'b00, 2'b00, 8'b0_00_00_1_1_0);
        tbl[13] = row(0, 4'h0, 1, 2'b01, 0, 2'b00, 2'b00, 8'b0_00_00_0_1_0);
        tbl[14] = row(0, 4'h0, 1, 2'b11, 0, 2'b00, 2'b00, 8'b0_00_00_0_1_0);
        tbl[15] = row(0, 4'h0, 0, 2'b00, 1, 2'b10, 2'b00, 8'b0_01_10_0_0_0);
        tbl[16] = row(0, 4'h0, 1, 2'b11, 0, 2'b00, 2'b00, 8'b0_00_00_0_0_0);
        tbl[17] = row(0, 4'h0, 1, 2'b11, 0, 2'b00, 2'b01, 8'b0_00_00_0_0_0);
        tbl[18] = row(0, 4'h0, 1, 2'b11, 0, 2'b00, 2'b01, 8'b0_00_00_0_0_0);
        tbl[19] = row(1, 4'h0, 0, 2'b00, 0, 2'b00, 2'b00, 8'b1_00_00_0_0_0);
        tbl[20] = row(0, 4'h0, 0, 2'b00, 0, 2'b00, 2'b00, 8'b0_00_00_1_1_0);
        tbl[21] = row(0, 4'h0, 1, 2'b01, 0, 2'b00, 2'b00, 8'b0_00_00_0_1_0);
        tbl[22] = row(1, 4'hF, 0, 2'b00, 1, 2'b11, 2'b00, 8'b1_11_11_0_0_0);
        tbl[23] = row(0, 4'h0, 0, 2'b00, 0, 2'b00, 2'b00, 8'b0_00_00_1_1_0);
        tbl[24] = row(0, 4'h0, 0, 2'b00, 1, 2'b10, 2'b00, 8'b0_00_00_1_0_0);

        reset = 1'b1;
        idle();
        idle();
        check("reset", 8'b1_00_00_0_0_0);
        reset = 1'b0;

        foreach (tbl[i]) begin
            cyc(tbl[i].st, tbl[i].su, tbl[i].v1, tbl[i].m1, tbl[i].v2, tbl[i].m2, tbl[i].pa);
            check($sformatf("table[%0d]", i), tbl[i].exp);
        end

        for (int k = 0; k < 3000; k++) begin
            cyc($urandom_range(0, 39) == 0, 4'($urandom), 1'($urandom), 2'($urandom),
                1'($urandom), 2'($urandom), $urandom_range(0, 7) == 0 ? 2'($urandom_range(1, 3)) : 2'b00);
            check($sformatf("model[%0d]", k), mexp);
        end

        cyc(1'b1, 4'h0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00);
        check("lone_start", 8'b1_00_00_0_0_0);
        idle();
        check("lone_collect", 8'b0_00_00_1_1_0);
        cyc(1'b0, 4'h0, 1'b1, 2'b11, 1'b0, 2'b00, 2'b00);
        check("lone_accept", 8'b0_00_00_0_1_0);
        for (int k = 1; k <= 4; k++) begin
            idle();
            check($sformatf("lone_wait%0d", k), 8'b0_00_00_0_1_0);
        end
`ifdef MOVE_TIMEOUT_EN
        idle();
        check("timeout_pulse", 8'b0_00_00_1_1_1);
        idle();
        check("timeout_end", 8'b0_00_00_1_1_0);
        cyc(1'b0, 4'h0, 1'b1, 2'b01, 1'b0, 2'b00, 2'b00);
        for (int k = 1; k <= 4; k++) begin
            idle();
            check($sformatf("race_wait%0d", k), 8'b0_00_00_0_1_0);
        end
        cyc(1'b0, 4'h0, 1'b0, 2'b00, 1'b1, 2'b10, 2'b00);
        check("race_issue", 8'b0_01_10_0_0_0);
`else
        for (int k = 5; k <= 8; k++) begin
            idle();
            check($sformatf("lone_hold%0d", k), 8'b0_00_00_0_1_0);
        end
`endif

        cyc(1'b1, 4'h0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00);
        idle();
        cyc(1'b0, 4'h0, 1'b1, 2'b01, 1'b1, 2'b01, 2'b00);
        check("pre_reset_issue", 8'b0_01_01_0_0_0);
        reset = 1'b1;
        idle();
        check("reset_mid_issue", 8'b1_00_00_0_0_0);
        reset = 1'b0;
        idle();
        check("post_reset_idle", 8'b0_00_00_0_0_0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
